// File: rtl/riscv_pkg.sv
// Shared types and helpers for the operand-fetch stage of the risky pipeline.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;
    typedef logic [NREG-1:0]       busy_vec_t;

    localparam reg_addr_t REG_X0 = 5'd0;

    // Payload that rides alongside the resolved operands into execute.
    typedef struct packed {
        reg_addr_t rd;
        logic      rd_we;
        xword_t    imm;
        xword_t    pc;
    } of_payload_t;

    // Resolve one source operand: x0 is hard zero, then same-cycle writeback
    // bypass, otherwise the register file's combinational read data.
    function automatic xword_t resolve_operand(
        input reg_addr_t rs,
        input logic      wb_valid,
        input reg_addr_t wb_rd,
        input xword_t    wb_data,
        input xword_t    rf_rdata
    );
        xword_t val;
        if (rs == REG_X0) begin
            val = '0;
        end else if (wb_valid && (wb_rd == rs)) begin
            val = wb_data;
        end else begin
            val = rf_rdata;
        end
        return val;
    endfunction

    // Read-after-write hazard for one source. A busy bit being cleared by
    // this cycle's writeback is not a hazard because the bypass supplies the
    // value. The held output entry is checked separately since its busy bit
    // only appears the cycle after it is handed to execute.
    function automatic logic raw_hazard(
        input reg_addr_t rs,
        input busy_vec_t busy,
        input logic      wb_valid,
        input reg_addr_t wb_rd,
        input logic      held_valid,
        input logic      held_rd_we,
        input reg_addr_t held_rd
    );
        logic busy_hit;
        logic held_hit;
        busy_hit = busy[rs] && !(wb_valid && (wb_rd == rs));
        held_hit = held_valid && held_rd_we && (held_rd == rs);
        return (rs != REG_X0) && (busy_hit || held_hit);
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard: one flop per architectural register awaiting writeback.
// Latency: set/clear become visible on busy one cycle after the request.
// Backpressure: none; set and clear are accepted every cycle, set wins on a collision.
module operand_fetch_scoreboard
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rstd,
    input  logic            set_en,
    input  logic [4:0]      set_addr,
    input  logic            clr_en,
    input  logic [4:0]      clr_addr,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_next;

    // Apply clear first so a same-cycle set on the same register wins; x0 never busy.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[REG_X0] = 1'b0;
    end

    // Busy flops, dropped immediately on reset.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file, bypasses writeback, stalls RAW hazards.
// Latency: decode handshake at edge N presents ex_valid from N+1; 1 instr/cycle.
// Backpressure: one-entry output register; id_ready drops on hazard, flush, or full-and-stalled.
module operand_fetch
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rstd,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_we,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,

    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,

    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,

    input  logic            flush,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc
);

    // Held output entry.
    logic        valid_q;
    xword_t      rs1_q;
    xword_t      rs2_q;
    of_payload_t pl_q;

    // Decode-side combinational results.
    xword_t      rs1_val;
    xword_t      rs2_val;
    of_payload_t id_pl;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        hazard;
    logic        slot_free;
    logic        capture;
    logic        issue;

    logic [NREG-1:0] busy;

    // The register file is addressed straight from decode.
    assign rf_raddr1 = id_rs1;
    assign rf_raddr2 = id_rs2;

    // Operand resolution for both sources and packing of the passthrough payload.
    always_comb begin
        rs1_val     = resolve_operand(id_rs1, wb_valid, wb_rd, wb_data, rf_rdata1);
        rs2_val     = resolve_operand(id_rs2, wb_valid, wb_rd, wb_data, rf_rdata2);
        id_pl       = '0;
        id_pl.rd    = id_rd;
        id_pl.rd_we = id_rd_we;
        id_pl.imm   = id_imm;
        id_pl.pc    = id_pc;
    end

    // Hazard check on both sources; decode zeroes unused sources so x0 never stalls.
    always_comb begin
        hazard_rs1 = raw_hazard(id_rs1, busy, wb_valid, wb_rd, valid_q, pl_q.rd_we, pl_q.rd);
        hazard_rs2 = raw_hazard(id_rs2, busy, wb_valid, wb_rd, valid_q, pl_q.rd_we, pl_q.rd);
        hazard     = hazard_rs1 || hazard_rs2;
    end

    // Handshake decisions: accept only when the slot is empty or draining this cycle.
    always_comb begin
        slot_free = !valid_q || ex_ready;
        id_ready  = !flush && !hazard && slot_free;
        capture   = id_valid && id_ready;
        issue     = valid_q && ex_ready;
    end

    // Output valid: set on capture, cleared by drain or flush (flush already blocks capture).
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
        end else if (flush || ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Output data: loads only on capture so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            rs1_q <= '0;
            rs2_q <= '0;
            pl_q  <= '0;
        end else if (capture) begin
            rs1_q <= rs1_val;
            rs2_q <= rs2_val;
            pl_q  <= id_pl;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_rs1_val = rs1_q;
    assign ex_rs2_val = rs2_q;
    assign ex_rd      = pl_q.rd;
    assign ex_rd_we   = pl_q.rd_we;
    assign ex_imm     = pl_q.imm;
    assign ex_pc      = pl_q.pc;

    // Destination goes busy once execute takes the entry; writeback retires it.
    operand_fetch_scoreboard u_scoreboard (
        .clk      (clk),
        .rstd     (rstd),
        .set_en   (issue && pl_q.rd_we),
        .set_addr (pl_q.rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .busy     (busy)
    );

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rstd = 1'b0;
    always #5 clk = ~clk;

    logic            id_valid, id_ready;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_rd_we;
    logic [XLEN-1:0] id_imm, id_pc;
    logic [4:0]      rf_raddr1, rf_raddr2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
    logic [4:0]      ex_rd;
    logic            ex_rd_we;

    operand_fetch dut (
        .clk(clk), .rstd(rstd),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_imm(id_imm), .id_pc(id_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_imm(ex_imm), .ex_pc(ex_pc)
    );

    // Register file model: x0 deliberately reads as garbage.
    xword_t rf_mem [NREG];
    assign rf_rdata1 = (rf_raddr1 == REG_X0) ? 32'hDEADBEEF : rf_mem[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == REG_X0) ? 32'hDEADBEEF : rf_mem[rf_raddr2];

    typedef struct packed {
        xword_t    v1;
        xword_t    v2;
        reg_addr_t rd;
        logic      we;
        xword_t    imm;
        xword_t    pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_a, mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every execute handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rstd && ex_valid && ex_ready) begin
            mon_a = '{ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we, ex_imm, ex_pc};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got %0h expected no entry", mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue", mon_a, mon_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                          input logic we, input xword_t imm, input xword_t pc);
        id_valid = 1'b1;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_rd_we = we;
        id_imm   = imm;
        id_pc    = pc;
    endtask

    // Present one instruction, wait (bounded) for acceptance, queue its expected result.
    task automatic issue(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                         input logic we, input xword_t imm, input xword_t pc,
                         input xword_t v1, input xword_t v2, output int waited);
        logic accepted;
        exp_t e;
        set_id(rs1, rs2, rd, we, imm, pc);
        waited   = 0;
        accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (id_ready) begin
                accepted = 1'b1;
                break;
            end
            waited++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: pc %0h not accepted in 40 cycles", pc);
            id_valid = 1'b0;
        end else begin
            step();
            e = '{v1, v2, rd, we, imm, pc};
            exp_q.push_back(e);
            id_valid = 1'b0;
        end
    endtask

    int w;

    initial begin
        for (int i = 0; i < NREG; i++) rf_mem[i] = 32'h1000 + i;
        rf_mem[5] = 32'h0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_we = 0;
        id_imm = 0; id_pc = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        flush = 0; ex_ready = 1;

        // Power-on reset state.
        #12;
        check("reset_ex_valid", ex_valid, 0);
        check("reset_payload", {ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we, ex_imm, ex_pc}, 0);
        check("reset_busy", dut.busy, 0);
        rstd = 1'b1;
        @(negedge clk);
        check("id_ready_after_reset", id_ready, 1);
        step();

        // x0 source reads zero despite the register file.
        issue(5'd0, 5'd2, 5'd1, 1'b0, 32'h11, 32'h100, 32'h0, 32'h1002, w);

        // Same-cycle writeback bypass.
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        issue(5'd5, 5'd0, 5'd2, 1'b0, 32'h22, 32'h104, 32'h1234, 32'h0, w);
        wb_valid = 1'b0;

        // Independent back-to-back instructions at full rate.
        issue(5'd3, 5'd4, 5'd0, 1'b0, 32'h31, 32'h108, 32'h1003, 32'h1004, w);
        issue(5'd6, 5'd8, 5'd0, 1'b0, 32'h32, 32'h10c, 32'h1006, 32'h1008, w);
        check("b2b_stall_a", w, 0);
        issue(5'd9, 5'd10, 5'd0, 1'b0, 32'h33, 32'h110, 32'h1009, 32'h100a, w);
        check("b2b_stall_b", w, 0);

        // RAW: producer writes x7, consumer reads x7 as rs2.
        issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h40, 32'h120, 32'h1001, 32'h1002, w);
        set_id(5'd0, 5'd7, 5'd8, 1'b0, 32'h44, 32'h124);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("raw_stall", id_ready, 0);
            step();
        end
        check("raw_busy7_set", dut.busy[7], 1);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
        @(negedge clk);
        check("raw_release", id_ready, 1);
        step();
        exp_q.push_back('{32'h0, 32'hAA, 5'd8, 1'b0, 32'h44, 32'h124});
        id_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        check("raw_busy7_clear", dut.busy[7], 0);
        step();
        step();

        // Backpressure holds the payload, then flush drops it without capture.
        ex_ready = 1'b0;
        issue(5'd3, 5'd4, 5'd9, 1'b1, 32'h55, 32'h200, 32'h1003, 32'h1004, w);
        set_id(5'd1, 5'd2, 5'd12, 1'b0, 32'h66, 32'h204);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_payload", {ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we, ex_imm, ex_pc},
                  {1'b1, 32'h1003, 32'h1004, 5'd9, 1'b1, 32'h55, 32'h200});
            check("hold_block", id_ready, 0);
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_block", id_ready, 0);
        step();
        flush = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        check("flush_clear", ex_valid, 0);
        check("flush_busy", dut.busy, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        ex_ready = 1'b1;
        step();

        // Execute handshake and writeback on x3 in the same cycle: set wins.
        issue(5'd0, 5'd0, 5'd3, 1'b1, 32'h77, 32'h300, 32'h0, 32'h0, w);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h99;
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        check("collision_set_wins", dut.busy[3], 1);
        step();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h99;
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        check("busy3_cleared", dut.busy[3], 0);
        step();

        // rd=x0 with rd_we never marks anything busy.
        issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h88, 32'h304, 32'h0, 32'h0, w);
        step();
        step();
        check("x0_not_busy", dut.busy, 0);

        // Reset mid-stream drops the held entry and all busy bits.
        issue(5'd1, 5'd1, 5'd11, 1'b1, 32'hA0, 32'h400, 32'h1001, 32'h1001, w);
        step();
        @(negedge clk);
        check("busy11_set", dut.busy[11], 1);
        step();
        ex_ready = 1'b0;
        issue(5'd2, 5'd3, 5'd10, 1'b1, 32'hB0, 32'h404, 32'h1002, 32'h1003, w);
        #2 rstd = 1'b0;
        #1;
        check("midreset_ex_valid", ex_valid, 0);
        check("midreset_payload", {ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we, ex_imm, ex_pc}, 0);
        check("midreset_busy", dut.busy, 0);
        exp_q.delete();
        @(negedge clk);
        rstd = 1'b1;
        ex_ready = 1'b1;
        #1;
        check("midreset_id_ready", id_ready, 1);
        step();
        issue(5'd11, 5'd0, 5'd0, 1'b0, 32'hC0, 32'h408, 32'h100b, 32'h0, w);
        check("post_reset_no_stall", w, 0);

        // Let the last entry drain through the monitor.
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
